rst_irq_controller: RTL and testbench
=====================================

// Module: rst_irq_controller
// PURPOSE
//   Parametrised vectored interrupt controller for the i8080 system bus; successor to the fixed
//   two-source mid_screen/vblank RST glue. Latches rising edges on NUM_SOURCES request lines,
//   masks and prioritises them, and raises iint. During the INTA read it drives RST n.
//   Sits beside the I/O decoders in the top level; mask/pending registers are I/O-port mapped.
// PARAMETERS
//   XLEN         8      data bus width (only 8 supported)
//   NUM_SOURCES  2      interrupt sources, 1..8
//   VECTOR_BASE  1      source i vectors to RST (VECTOR_BASE+i); VECTOR_BASE+NUM_SOURCES-1 <= 7
//   SYNC_STAGES  2      synchroniser flops per source, 0 = bypass (source already in clk domain)
//   MASK_PORT    8'h07  OUT port: write mask; IN port: read mask
//   PEND_PORT    8'h08  IN port: read pending bits (read-only)
//   MASK_RESET   all 1s mask value after reset
// PORTS
//   clk         in   1            system clock
//   rst         in   1            asynchronous reset, active-high
//   src         in   NUM_SOURCES  interrupt request levels; rising edge = request
//   status_inta in   1            latched status word INTA bit
//   status_inp  in   1            latched status word INP bit
//   status_out  in   1            latched status word OUT bit
//   dbin        in   1            CPU read strobe
//   write_n     in   1            CPU write strobe, active-low
//   io_addr     in   XLEN         low address byte, which holds the I/O port number
//   data_in     in   XLEN         data bus as seen by this block
//   data_out    out  XLEN         value to drive onto the bus
//   data_oe     out  1            top level tri-states data to data_out when high
//   iint        out  1            interrupt request to CPU
//   ack_src     out  NUM_SOURCES  one-hot pulse: source acknowledged this cycle
// BEHAVIOUR
//   Reset: pending=0, mask=MASK_RESET, state=IDLE, iint=0, data_oe=0, data_out=0, ack_src=0.
//     Sync chains and edge history are all cleared.
//   Edge detect: rise = sync_now & ~sync_prev per source.
//     Latency src -> pending is SYNC_STAGES+1 clk.
//   Pending update each clk:
//     pending <= ((pending & ~clr) | (rise & mask)) & mask_next.
//     Set wins over clear for the same bit. Edges on masked sources are dropped, not queued.
//   Mask write: when ~write_n & status_out & io_addr==MASK_PORT, mask <= data_in[NUM_SOURCES-1:0].
//     Bits cleared in the mask clear the matching pending bits in the same edge.
//   iint = |(pending & mask), registered. It deasserts the cycle after the last pending bit clears.
//   Priority: lowest set index wins (source 0 highest).
//   FSM, states IDLE, ACK:
//     IDLE -> ACK on the first clk with dbin & status_inta.
//       Latch ack_idx = winner and ack_valid = |pending.
//     ACK: vector held stable for the whole dbin window, even if a higher-priority edge arrives.
//     ACK -> IDLE on the first clk with ~dbin.
//       If ack_valid: clear pending[ack_idx] and pulse ack_src[ack_idx] for 1 clk.
//     Reset mid-ACK: return to IDLE; no clear, no pulse.
//   Bus drive (combinational from regs/inputs):
//     dbin & status_inta: data_oe=1.
//       data_out = ack_valid ? {2'b11, VECTOR_BASE+ack_idx, 3'b111} : 8'h00 (NOP, spurious INTA).
//       In the first INTA cycle use the live winner, so the vector is valid immediately.
//     dbin & status_inp & io_addr==PEND_PORT: data_oe=1, data_out = zero-extended pending.
//     dbin & status_inp & io_addr==MASK_PORT: data_oe=1, data_out = zero-extended mask.
//     Otherwise data_oe=0 and data_out=0.
//   Elaboration: $error if NUM_SOURCES<1, NUM_SOURCES>8, VECTOR_BASE+NUM_SOURCES>8, or XLEN!=8.
// STRUCTURE
//   Shared i8080.vh gains `I8080_RST_OPCODE(n) ({2'b11,(n),3'b111}) and `I8080_NOP (8'h00).
//   The status-bit macros there are reused.
//   Sub-module edge_sync (WIDTH=1, STAGES): sync chain + rising-edge pulse, one instance per source.
//     Generated with a for-loop.
//   The priority encoder and FSM live inline. Tri-state drive stays in the top level.
// TESTING
//   1. NUM_SOURCES=2, VECTOR_BASE=1: pulse src[1].
//      -> iint high at SYNC_STAGES+2 clk.
//      -> INTA read returns 8'hD7 (RST 2); ack_src=2'b10 on dbin fall; iint low next clk.
//   2. src[0] and src[1] rise on the same clk.
//      -> first INTA returns 8'hCF (RST 1); second INTA returns 8'hD7; then iint=0.
//   3. Write mask=2'b01 via OUT MASK_PORT, then pulse src[1].
//      -> IN PEND_PORT reads 8'h00; iint stays 0.
//      -> With src[1] pending, clearing its mask bit drops iint next clk.
//   4. Inside an ACK of src[1], src[0] rises.
//      -> vector stays 8'hD7 through dbin; after the ack, pending=2'b01 and iint stays 1.
//      -> Same test with src[1] re-rising during its own ACK: pending[1] remains set.
//   5. INTA with pending=0.
//      -> data_out=8'h00, data_oe=1, ack_src stays 0, pending unchanged.
//   6. Assert rst mid-ACK and mid-sync.
//      -> all outputs, pending and mask return to reset values asynchronously; no ack pulse.

Source files
------------

// File: rtl/rst_irq_controller_pkg.sv
// Shared types and helpers for the RST vectored interrupt controller.
//   state_e     : INTA acknowledge FSM states
//   I8080_NOP   : byte returned on a spurious INTA (no source pending)
//   rst_opcode  : builds the i8080 RST n opcode byte
package rst_irq_controller_pkg;

    localparam int MAX_SOURCES = 8;

    localparam logic [7:0] I8080_NOP = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    // RST n is encoded as 11 nnn 111.
    function automatic logic [7:0] rst_opcode(input logic [2:0] n);
        return {2'b11, n, 3'b111};
    endfunction

endpackage

// File: rtl/rst_irq_controller_if.sv
// CPU-side bus bundle for the interrupt controller.
//   master : CPU/top-level side (drives status bits, strobes, address, data_in)
//   slave  : controller side (drives data_out and data_oe)
interface rst_irq_controller_if #(
    parameter int XLEN = 8
) ();
    logic            status_inta;
    logic            status_inp;
    logic            status_out;
    logic            dbin;
    logic            write_n;
    logic [XLEN-1:0] io_addr;
    logic [XLEN-1:0] data_in;
    logic [XLEN-1:0] data_out;
    logic            data_oe;

    modport master (
        output status_inta, status_inp, status_out, dbin, write_n, io_addr, data_in,
        input  data_out, data_oe
    );

    modport slave (
        input  status_inta, status_inp, status_out, dbin, write_n, io_addr, data_in,
        output data_out, data_oe
    );
endinterface

// File: rtl/rst_irq_controller_edge_sync.sv
// Synchroniser chain followed by a rising-edge detector.
//   clk, rst : clock and asynchronous active-high reset
//   d        : asynchronous input level(s)
//   rise     : one-clk pulse when the synchronised level goes 0 -> 1
// STAGES = 0 bypasses the chain for inputs already in the clk domain.
module rst_irq_controller_edge_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] sync_now;
    logic [WIDTH-1:0] sync_prev;

    if (STAGES == 0) begin : g_bypass
        assign sync_now = d;
    end else begin : g_chain
        logic [WIDTH-1:0] sync_p [STAGES];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < STAGES; s++) sync_p[s] <= '0;
            end else begin
                sync_p[0] <= d;
                for (int s = 1; s < STAGES; s++) sync_p[s] <= sync_p[s-1];
            end
        end

        assign sync_now = sync_p[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_prev <= '0;
        else     sync_prev <= sync_now;
    end

    assign rise = sync_now & ~sync_prev;
endmodule

// File: rtl/rst_irq_controller.sv
// Vectored RST interrupt controller for the i8080 system bus.
//   clk, rst : system clock, asynchronous active-high reset
//   src      : interrupt request levels, a rising edge requests service
//   bus      : status bits, strobes, I/O port address and data (slave side)
//   iint     : registered interrupt request to the CPU
//   ack_src  : one-hot, one-clk pulse naming the source just acknowledged
// Mask is written by OUT MASK_PORT and read by IN MASK_PORT; pending bits
// are read by IN PEND_PORT. During INTA the controller supplies RST n.
module rst_irq_controller
    import rst_irq_controller_pkg::*;
#(
    parameter int                     XLEN        = 8,
    parameter int                     NUM_SOURCES = 2,
    parameter int                     VECTOR_BASE = 1,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [XLEN-1:0]        MASK_PORT   = 8'h07,
    parameter logic [XLEN-1:0]        PEND_PORT   = 8'h08,
    parameter logic [NUM_SOURCES-1:0] MASK_RESET  = '1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] src,
    rst_irq_controller_if.slave    bus,
    output logic                   iint,
    output logic [NUM_SOURCES-1:0] ack_src
);
    if (NUM_SOURCES < 1 || NUM_SOURCES > MAX_SOURCES ||
        VECTOR_BASE + NUM_SOURCES > 8 || XLEN != 8) begin : g_bad_params
        $error("rst_irq_controller: unsupported XLEN/NUM_SOURCES/VECTOR_BASE combination");
    end

    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] mask_next;
    logic [NUM_SOURCES-1:0] clr;
    logic                   mask_wr;
    logic [2:0]             winner;
    logic [2:0]             ack_idx;
    logic                   ack_valid;
    logic                   latch_ack;
    logic                   ack_done;
    logic [2:0]             vec_idx;
    logic                   vec_valid;
    state_e                 state;
    state_e                 state_next;

    // Only the low NUM_SOURCES data bits carry mask state.
    logic unused_data_in;
    assign unused_data_in = ^bus.data_in;

    for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
        rst_irq_controller_edge_sync #(
            .WIDTH  (1),
            .STAGES (SYNC_STAGES)
        ) u_edge_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (src[i]),
            .rise (rise[i])
        );
    end

    assign mask_wr   = ~bus.write_n & bus.status_out & (bus.io_addr == MASK_PORT);
    assign mask_next = mask_wr ? bus.data_in[NUM_SOURCES-1:0] : mask;

    // Lowest pending index wins; scanning downward leaves the lowest last.
    always_comb begin
        winner = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (pending[i]) winner = 3'(i);
        end
    end

    // Acknowledge FSM: next state and control strobes.
    always_comb begin
        state_next = state;
        latch_ack  = 1'b0;
        ack_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.dbin && bus.status_inta) begin
                    state_next = ST_ACK;
                    latch_ack  = 1'b1;
                end
            end
            ST_ACK: begin
                if (!bus.dbin) begin
                    state_next = ST_IDLE;
                    ack_done   = ack_valid;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            clr[i] = ack_done && (ack_idx == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Pending/mask/ack registers; a new edge beats an ack clear on the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            mask      <= MASK_RESET;
            iint      <= 1'b0;
            ack_src   <= '0;
            ack_idx   <= '0;
            ack_valid <= 1'b0;
        end else begin
            pending <= ((pending & ~clr) | (rise & mask)) & mask_next;
            mask    <= mask_next;
            iint    <= |(pending & mask);
            ack_src <= clr;
            if (latch_ack) begin
                ack_idx   <= winner;
                ack_valid <= |pending;
            end
        end
    end

    // The first INTA cycle has not latched yet, so it uses the live winner.
    always_comb begin
        vec_idx   = ack_idx;
        vec_valid = ack_valid;
        if (state == ST_IDLE) begin
            vec_idx   = winner;
            vec_valid = |pending;
        end
    end

    always_comb begin
        bus.data_oe  = 1'b0;
        bus.data_out = '0;
        if (bus.dbin && bus.status_inta) begin
            bus.data_oe  = 1'b1;
            bus.data_out = vec_valid ? rst_opcode(3'(VECTOR_BASE) + vec_idx) : I8080_NOP;
        end else if (bus.dbin && bus.status_inp && bus.io_addr == PEND_PORT) begin
            bus.data_oe  = 1'b1;
            bus.data_out = XLEN'(pending);
        end else if (bus.dbin && bus.status_inp && bus.io_addr == MASK_PORT) begin
            bus.data_oe  = 1'b1;
            bus.data_out = XLEN'(mask);
        end
    end
endmodule

// File: tb/tb_rst_irq_controller.sv
`timescale 1ns/1ps
module tb_rst_irq_controller;
    localparam int NS = 2;
    localparam int S  = 2;
    localparam int VB = 1;
    localparam logic [7:0] MASK_PORT = 8'h07;
    localparam logic [7:0] PEND_PORT = 8'h08;

    typedef logic [NS-1:0] nvec_t;

    logic  clk = 1'b0;
    logic  rst;
    nvec_t src;
    logic  iint;
    nvec_t ack_src;

    rst_irq_controller_if #(.XLEN(8)) bus ();

    rst_irq_controller #(
        .XLEN        (8),
        .NUM_SOURCES (NS),
        .VECTOR_BASE (VB),
        .SYNC_STAGES (S),
        .MASK_PORT   (MASK_PORT),
        .PEND_PORT   (PEND_PORT),
        .MASK_RESET  (2'b11)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .src     (src),
        .bus     (bus),
        .iint    (iint),
        .ack_src (ack_src)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.status_inta = 1'b0;
        bus.status_inp  = 1'b0;
        bus.status_out  = 1'b0;
        bus.dbin        = 1'b0;
        bus.write_n     = 1'b1;
        bus.io_addr     = 8'h00;
        bus.data_in     = 8'h00;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        src = '0;
        bus_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.io_addr    = MASK_PORT;
        bus.data_in    = m;
        bus.status_out = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic read_port(input logic [7:0] port, output logic [7:0] v, output logic oe);
        bus.io_addr    = port;
        bus.status_inp = 1'b1;
        bus.dbin       = 1'b1;
        #1;
        v  = bus.data_out;
        oe = bus.data_oe;
        bus_idle();
        #1;
    endtask

    task automatic pulse_src(input nvec_t p);
        src = p;
        tick();
        src = '0;
    endtask

    // Full INTA read: vector in first cycle, vector one clk later, ack pulse after dbin falls.
    task automatic inta(output logic [7:0] v_first, output logic [7:0] v_held,
                        output logic oe, output nvec_t ack);
        bus.status_inta = 1'b1;
        bus.dbin        = 1'b1;
        #1;
        v_first = bus.data_out;
        oe      = bus.data_oe;
        tick();
        v_held = bus.data_out;
        bus.dbin        = 1'b0;
        bus.status_inta = 1'b0;
        tick();
        ack = ack_src;
    endtask

    // ---------------- reference model ----------------
    nvec_t hist[$];
    nvec_t m_pend, m_mask, m_ack;
    logic  m_iint, m_busy, m_valid;
    int    m_idx;

    function automatic int lowest_set(input nvec_t v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] rst_code(input int n);
        return 8'(8'hC7 + 8 * n);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 2; i++) hist.push_back('0);
        m_pend  = '0;
        m_mask  = '1;
        m_ack   = '0;
        m_iint  = 1'b0;
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
    endtask

    task automatic model_expect(output logic [7:0] e_out, output logic e_oe);
        e_out = 8'h00;
        e_oe  = 1'b0;
        if (bus.dbin && bus.status_inta) begin
            e_oe = 1'b1;
            if (!m_busy) begin
                if (m_pend != 0) e_out = rst_code(VB + lowest_set(m_pend));
            end else if (m_valid) begin
                e_out = rst_code(VB + m_idx);
            end
        end else if (bus.dbin && bus.status_inp && bus.io_addr == PEND_PORT) begin
            e_oe  = 1'b1;
            e_out = 8'(m_pend);
        end else if (bus.dbin && bus.status_inp && bus.io_addr == MASK_PORT) begin
            e_oe  = 1'b1;
            e_out = 8'(m_mask);
        end
    endtask

    task automatic model_step();
        nvec_t rise, clr, nmask;
        int    n;
        hist.push_back(src);
        n = hist.size();
        for (int i = 0; i < NS; i++) rise[i] = hist[n-1-S][i] && !hist[n-2-S][i];
        void'(hist.pop_front());
        for (int i = 0; i < NS; i++) clr[i] = m_busy && !bus.dbin && m_valid && (i == m_idx);
        if (!bus.write_n && bus.status_out && bus.io_addr == MASK_PORT) nmask = bus.data_in[NS-1:0];
        else nmask = m_mask;
        m_iint = (m_pend & m_mask) != 0;
        m_ack  = clr;
        if (!m_busy && bus.dbin && bus.status_inta) begin
            m_busy  = 1'b1;
            m_idx   = lowest_set(m_pend);
            m_valid = (m_pend != 0);
        end else if (m_busy && !bus.dbin) begin
            m_busy = 1'b0;
        end
        m_pend = ((m_pend & ~clr) | (rise & m_mask)) & nmask;
        m_mask = nmask;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        nvec_t      srcs;
        nvec_t      mask;
        logic       exp_iint;
        logic [7:0] exp_v1;
        nvec_t      exp_ack1;
        logic [7:0] exp_v2;
    } vec_t;

    vec_t tbl[7];

    logic [7:0] v1, v2, rd;
    logic       oe;
    nvec_t      ak;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e_out;
        logic       e_oe;

        rst = 1'b1;
        src = '0;
        bus_idle();

        // Reset state
        apply_reset();
        check("rst_iint", 8'(iint), 8'h00);
        check("rst_ack_src", 8'(ack_src), 8'h00);
        check("rst_data_oe", 8'(bus.data_oe), 8'h00);
        check("rst_data_out", bus.data_out, 8'h00);
        read_port(MASK_PORT, rd, oe);
        check("rst_mask", rd, 8'h03);
        check("rst_mask_oe", 8'(oe), 8'h01);
        read_port(PEND_PORT, rd, oe);
        check("rst_pend", rd, 8'h00);

        // 1: single src[1] pulse, latency and ack
        pulse_src(2'b10);
        tick();
        tick();
        check("t1_iint_early", 8'(iint), 8'h00);
        read_port(PEND_PORT, rd, oe);
        check("t1_pend", rd, 8'h02);
        tick();
        check("t1_iint", 8'(iint), 8'h01);
        inta(v1, v2, oe, ak);
        check("t1_vec_first", v1, 8'hD7);
        check("t1_vec_held", v2, 8'hD7);
        check("t1_oe", 8'(oe), 8'h01);
        check("t1_ack", 8'(ak), 8'h02);
        check("t1_iint_at_ack", 8'(iint), 8'h01);
        tick();
        check("t1_iint_after", 8'(iint), 8'h00);
        check("t1_ack_pulse_end", 8'(ack_src), 8'h00);

        // 2: simultaneous edges, priority order
        apply_reset();
        pulse_src(2'b11);
        repeat (3) tick();
        inta(v1, v2, oe, ak);
        check("t2_vec1", v1, 8'hCF);
        check("t2_ack1", 8'(ak), 8'h01);
        inta(v1, v2, oe, ak);
        check("t2_vec2", v1, 8'hD7);
        check("t2_ack2", 8'(ak), 8'h02);
        tick();
        check("t2_iint_after", 8'(iint), 8'h00);

        // 3: masking
        apply_reset();
        write_mask(8'h01);
        read_port(MASK_PORT, rd, oe);
        check("t3_mask_rd", rd, 8'h01);
        pulse_src(2'b10);
        repeat (4) tick();
        read_port(PEND_PORT, rd, oe);
        check("t3_pend_masked", rd, 8'h00);
        check("t3_iint_masked", 8'(iint), 8'h00);
        write_mask(8'h03);
        pulse_src(2'b10);
        repeat (3) tick();
        check("t3_iint_on", 8'(iint), 8'h01);
        write_mask(8'h01);
        read_port(PEND_PORT, rd, oe);
        check("t3_pend_cleared", rd, 8'h00);
        tick();
        check("t3_iint_drop", 8'(iint), 8'h00);

        // 4a: higher-priority edge during ACK of src[1]
        apply_reset();
        pulse_src(2'b10);
        repeat (3) tick();
        bus.status_inta = 1'b1;
        bus.dbin        = 1'b1;
        #1;
        check("t4_vec_first", bus.data_out, 8'hD7);
        tick();
        pulse_src(2'b01);
        tick();
        tick();
        check("t4_vec_held", bus.data_out, 8'hD7);
        bus.dbin        = 1'b0;
        bus.status_inta = 1'b0;
        tick();
        check("t4_ack", 8'(ack_src), 8'h02);
        read_port(PEND_PORT, rd, oe);
        check("t4_pend", rd, 8'h01);
        tick();
        check("t4_iint", 8'(iint), 8'h01);

        // 4b: src[1] re-rise lands on its own ack edge
        apply_reset();
        pulse_src(2'b10);
        repeat (3) tick();
        bus.status_inta = 1'b1;
        bus.dbin        = 1'b1;
        tick();
        pulse_src(2'b10);
        tick();
        bus.dbin        = 1'b0;
        bus.status_inta = 1'b0;
        tick();
        check("t4b_ack", 8'(ack_src), 8'h02);
        read_port(PEND_PORT, rd, oe);
        check("t4b_pend", rd, 8'h02);
        tick();
        check("t4b_iint", 8'(iint), 8'h01);

        // 5: spurious INTA
        apply_reset();
        inta(v1, v2, oe, ak);
        check("t5_vec", v1, 8'h00);
        check("t5_vec_held", v2, 8'h00);
        check("t5_oe", 8'(oe), 8'h01);
        check("t5_ack", 8'(ak), 8'h00);
        read_port(PEND_PORT, rd, oe);
        check("t5_pend", rd, 8'h00);

        // 6: reset mid-ACK and mid-sync
        apply_reset();
        write_mask(8'h01);
        pulse_src(2'b01);
        repeat (3) tick();
        check("t6_iint_pre", 8'(iint), 8'h01);
        bus.status_inta = 1'b1;
        bus.dbin        = 1'b1;
        tick();
        pulse_src(2'b01);
        rst = 1'b1;
        #1;
        check("t6_iint_async", 8'(iint), 8'h00);
        check("t6_vec_async", bus.data_out, 8'h00);
        bus_idle();
        #1;
        check("t6_oe", 8'(bus.data_oe), 8'h00);
        check("t6_ack_async", 8'(ack_src), 8'h00);
        tick();
        check("t6_ack_in_rst", 8'(ack_src), 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_ack_after", 8'(ack_src), 8'h00);
        end
        check("t6_iint_after", 8'(iint), 8'h00);
        read_port(MASK_PORT, rd, oe);
        check("t6_mask", rd, 8'h03);
        read_port(PEND_PORT, rd, oe);
        check("t6_pend", rd, 8'h00);

        // Table-driven scenarios
        tbl[0] = '{2'b10, 2'b11, 1'b1, 8'hD7, 2'b10, 8'h00};
        tbl[1] = '{2'b01, 2'b11, 1'b1, 8'hCF, 2'b01, 8'h00};
        tbl[2] = '{2'b11, 2'b11, 1'b1, 8'hCF, 2'b01, 8'hD7};
        tbl[3] = '{2'b10, 2'b01, 1'b0, 8'h00, 2'b00, 8'h00};
        tbl[4] = '{2'b11, 2'b10, 1'b1, 8'hD7, 2'b10, 8'h00};
        tbl[5] = '{2'b00, 2'b11, 1'b0, 8'h00, 2'b00, 8'h00};
        tbl[6] = '{2'b01, 2'b10, 1'b0, 8'h00, 2'b00, 8'h00};
        for (int k = 0; k < 7; k++) begin
            apply_reset();
            write_mask(8'(tbl[k].mask));
            pulse_src(tbl[k].srcs);
            repeat (3) tick();
            check($sformatf("tbl%0d_iint", k), 8'(iint), 8'(tbl[k].exp_iint));
            inta(v1, v2, oe, ak);
            check($sformatf("tbl%0d_v1", k), v1, tbl[k].exp_v1);
            check($sformatf("tbl%0d_ack1", k), 8'(ak), 8'(tbl[k].exp_ack1));
            inta(v1, v2, oe, ak);
            check($sformatf("tbl%0d_v2", k), v1, tbl[k].exp_v2);
        end

        // Randomized run against the reference model
        apply_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) src = nvec_t'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.dbin = ~bus.dbin;
            bus.status_inta = ($urandom_range(0, 2) == 0);
            bus.status_inp  = ($urandom_range(0, 2) == 0);
            bus.status_out  = ($urandom_range(0, 2) == 0);
            bus.write_n     = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 3))
                0:       bus.io_addr = MASK_PORT;
                1:       bus.io_addr = PEND_PORT;
                default: bus.io_addr = 8'($urandom);
            endcase
            bus.data_in = 8'($urandom);
            #1;
            model_expect(e_out, e_oe);
            check($sformatf("rnd%0d_data_out", c), bus.data_out, e_out);
            check($sformatf("rnd%0d_data_oe", c), 8'(bus.data_oe), 8'(e_oe));
            check($sformatf("rnd%0d_iint", c), 8'(iint), 8'(m_iint));
            check($sformatf("rnd%0d_ack_src", c), 8'(ack_src), 8'(m_ack));
            tick();
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
